// File: rtl/seq_det_scheduler.sv
// Word-to-serial scheduler for a 0110 Mealy sequence detector: shifts each accepted
// word MSB-first into the detector and returns a saturating per-word hit count.
module seq_det_scheduler #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_cont,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             det_clr,
    output logic             det_en,
    output logic             det_din,
    input  logic             det_dout,
    output logic [CNT_W-1:0] res_count,
    output logic             res_hit,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
);

    localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SHIFT,
        REPORT
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [BC_W-1:0]  bitcnt, bitcnt_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [CNT_W-1:0] res_count_q, res_count_nxt;
    logic             first_flag, first_flag_nxt;

    // NOTE: every state element, datapath included, sits on the async reset so an
    // aborted word leaves no residue that could leak into the next result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shreg       <= '0;
            bitcnt      <= '0;
            count       <= '0;
            res_count_q <= '0;
            first_flag  <= 1'b1;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state       <= state_nxt;
            shreg       <= shreg_nxt;
            bitcnt      <= bitcnt_nxt;
            count       <= count_nxt;
            res_count_q <= res_count_nxt;
            first_flag  <= first_flag_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned.
        state_nxt      = state;
        shreg_nxt      = shreg;
        bitcnt_nxt     = bitcnt;
        count_nxt      = count;
        res_count_nxt  = res_count_q;
        first_flag_nxt = first_flag;
        in_ready       = 1'b0;
        det_clr        = 1'b0;
        det_en         = 1'b0;
        det_din        = 1'b0;
        res_valid      = 1'b0;

        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shreg_nxt      = in_data;
                    bitcnt_nxt     = '0;
                    count_nxt      = '0;
                    first_flag_nxt = 1'b0;
                    // The very first word after reset always starts from a clean detector.
                    state_nxt      = (!in_cont || first_flag) ? CLEAR : SHIFT;
                end
            end

            CLEAR: begin
                det_clr   = 1'b1;
                state_nxt = SHIFT;
            end

            SHIFT: begin
                det_en     = 1'b1;
                det_din    = shreg[WIDTH-1];
                shreg_nxt  = {shreg[WIDTH-2:0], 1'b0};
                bitcnt_nxt = bitcnt + 1'b1;
                // det_dout is the Mealy response to the bit being consumed on this edge.
                if (det_dout && (count != CNT_MAX)) begin
                    count_nxt = count + 1'b1;
                end
                if (bitcnt == LAST_BIT) begin
                    res_count_nxt = count_nxt;
                    state_nxt     = REPORT;
                end
            end

            REPORT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    assign res_count = res_count_q;
    assign res_hit   = (res_count_q != '0);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Randomised and directed bench for seq_det_scheduler: a behavioural 0110 detector
// drives det_dout, and a bit-stream model predicts counts, clears and latency.
module tb_seq_det_scheduler;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- default instance (WIDTH=8, CNT_W=4) ----------------
    logic [7:0] in_data;
    logic       in_cont, in_valid, in_ready;
    logic       det_clr, det_en, det_din, det_dout;
    logic [3:0] res_count;
    logic       res_hit, res_valid, res_ready, busy;

    seq_det_scheduler #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_cont(in_cont), .in_valid(in_valid), .in_ready(in_ready),
        .det_clr(det_clr), .det_en(det_en), .det_din(det_din), .det_dout(det_dout),
        .res_count(res_count), .res_hit(res_hit), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy)
    );

    // ---------------- saturation instance (WIDTH=16, CNT_W=2) ----------------
    logic [15:0] w_in_data;
    logic        w_in_cont, w_in_valid, w_in_ready;
    logic        w_det_clr, w_det_en, w_det_din, w_det_dout;
    logic [1:0]  w_res_count;
    logic        w_res_hit, w_res_valid, w_res_ready, w_busy;

    seq_det_scheduler #(.WIDTH(16), .CNT_W(2)) dut_w (
        .clk(clk), .reset(reset),
        .in_data(w_in_data), .in_cont(w_in_cont), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .det_clr(w_det_clr), .det_en(w_det_en), .det_din(w_det_din), .det_dout(w_det_dout),
        .res_count(w_res_count), .res_hit(w_res_hit), .res_valid(w_res_valid),
        .res_ready(w_res_ready), .busy(w_busy)
    );

    // ---------------- behavioural overlapping 0110 Mealy detectors ----------------
    logic [2:0] dh, w_dh;
    int         dlen, w_dlen;

    assign det_dout   = det_en && (dlen >= 3) && ({dh, det_din} == 4'b0110);
    assign w_det_dout = w_det_en && (w_dlen >= 3) && ({w_dh, w_det_din} == 4'b0110);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            dh <= '0; dlen <= 0; w_dh <= '0; w_dlen <= 0;
        end else begin
            if (det_clr) begin
                dh <= '0; dlen <= 0;
            end else if (det_en) begin
                dh <= {dh[1:0], det_din};
                if (dlen < 3) dlen <= dlen + 1;
            end
            if (w_det_clr) begin
                w_dh <= '0; w_dlen <= 0;
            end else if (w_det_en) begin
                w_dh <= {w_dh[1:0], w_det_din};
                if (w_dlen < 3) w_dlen <= w_dlen + 1;
            end
        end
    end

    // ---------------- detector-side monitor ----------------
    int clr_seen, w_clr_seen;
    bit din_q[$];

    always @(posedge clk) begin
        if (det_clr) clr_seen++;
        if (det_en) din_q.push_back(det_din);
        if (w_det_clr) w_clr_seen++;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model: bit stream since last clear ----------------
    bit ref_hist[$];
    bit ref_first = 1'b1;

    function automatic int tail_matches(input bit q[$], input int n);
        int m = 0;
        for (int i = q.size() - n; i < q.size(); i++) begin
            if (i >= 3 && q[i-3] == 1'b0 && q[i-2] == 1'b1 && q[i-1] == 1'b1 && q[i] == 1'b0)
                m++;
        end
        return m;
    endfunction

    // Offer one word, check latency, detector traffic and result, then complete the
    // result handshake after `hold` stalled cycles (optionally with a pending word).
    task automatic do_word(input logic [7:0] w, input logic cont, input int hold,
                           input bit pend, input int want);
        int         n;
        int         raw, exp_cnt;
        bit         exp_clr;
        logic [7:0] dv;

        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_idle", in_ready, 1);

        exp_clr = !cont || ref_first;
        ref_first = 1'b0;
        if (exp_clr) ref_hist.delete();
        for (int i = 7; i >= 0; i--) ref_hist.push_back(w[i]);
        raw = tail_matches(ref_hist, 8);
        exp_cnt = (raw > 15) ? 15 : raw;
        if (want >= 0) check("spec_count", 32'(exp_cnt), 32'(want));

        clr_seen = 0;
        din_q.delete();
        in_data  = w;
        in_cont  = cont;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_after_accept", busy, 1);

        n = 0;
        while (!res_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        check("latency", 32'(n), exp_clr ? 32'd9 : 32'd8);
        check("clr_pulses", 32'(clr_seen), exp_clr ? 32'd1 : 32'd0);
        check("din_len", 32'(din_q.size()), 32'd8);
        dv = '0;
        for (int i = 0; i < din_q.size() && i < 8; i++) dv = {dv[6:0], din_q[i]};
        check("din_seq", dv, w);
        check("res_count", res_count, 32'(exp_cnt));
        check("res_hit", res_hit, (exp_cnt != 0) ? 32'd1 : 32'd0);

        if (pend) begin
            in_data  = ~w;
            in_cont  = 1'b0;
            in_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", res_valid, 1);
            check("hold_count", res_count, 32'(exp_cnt));
            check("hold_in_ready", in_ready, 0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_hs_valid", res_valid, 0);
        check("post_hs_idle", in_ready, 1);
        check("post_hs_retain", res_count, 32'(exp_cnt));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   n, raw16;
        bit   q16[$];
        logic [15:0] sat_word;

        reset = 1'b0;
        in_data = '0; in_cont = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        w_in_data = '0; w_in_cont = 1'b0; w_in_valid = 1'b0; w_res_ready = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_det", {det_clr, det_en, det_din}, 0);
        check("rst_res", {res_valid, res_hit, res_count}, 0);
        check("rst_busy", busy, 0);
        #12 reset = 1'b1;
        @(posedge clk); #1;

        // directed cases
        do_word(8'b0110_0000, 1'b0, 0, 1'b0, 1);
        do_word(8'b0110_1101, 1'b0, 0, 1'b0, 2);
        do_word(8'b0000_0011, 1'b0, 0, 1'b0, 0);
        do_word(8'b0101_0000, 1'b1, 0, 1'b0, 1);
        do_word(8'b0000_0011, 1'b0, 0, 1'b0, 0);
        do_word(8'b0101_0000, 1'b0, 0, 1'b0, 0);

        // backpressure with a word pending, then immediate next accept
        do_word(8'b0110_0110, 1'b0, 10, 1'b1, 2);
        do_word(8'b1011_0110, 1'b1, 0, 1'b0, -1);

        // asynchronous reset in the middle of SHIFT after three bits
        in_data = 8'b0110_1101; in_cont = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_det", {det_clr, det_en, det_din}, 0);
        check("midrst_res", {res_valid, res_hit, res_count}, 0);
        check("midrst_busy", busy, 0);
        #2 reset = 1'b1;
        ref_first = 1'b1;
        @(posedge clk); #1;
        do_word(8'b0110_0000, 1'b1, 0, 1'b0, 1);

        // randomised words, continuous mode and result stalls
        for (int k = 0; k < 30; k++) begin
            do_word(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, -1);
        end

        // saturation on the wide instance
        sat_word = 16'b0110_1101_1011_0110;
        for (int i = 15; i >= 0; i--) q16.push_back(sat_word[i]);
        raw16 = tail_matches(q16, 16);
        w_clr_seen = 0;
        check("w_in_ready", w_in_ready, 1);
        w_in_data = sat_word; w_in_cont = 1'b1; w_in_valid = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        n = 0;
        while (!w_res_valid && n < 60) begin
            @(posedge clk); #1; n++;
        end
        check("w_latency", 32'(n), 32'd17);
        check("w_clr_pulses", 32'(w_clr_seen), 32'd1);
        check("w_res_count", w_res_count, (raw16 > 3) ? 32'd3 : 32'(raw16));
        check("w_res_hit", w_res_hit, 1);
        w_res_ready = 1'b1;
        @(posedge clk); #1;
        w_res_ready = 1'b0;
        check("w_post_hs", {w_res_valid, w_busy}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
